shift_reg_engine: RTL
=====================

# shift_reg_engine

Parametrised successor to the universal shift register. It shifts LANE bits per step and adds rotate and arithmetic-right operations. Multi-step operations are issued as one command through a valid/ready handshake, and completion is reported with a done pulse. The block sits on the datapath wherever a word must be serialised, deserialised, aligned or barrel-stepped under sequencer control.

## Interface
- WIDTH, 8: register width in bits; must be at least 2.
- LANE, 1: bits moved per step. WIDTH must be a multiple of LANE, and LANE must be less than WIDTH.
- CNT_W, 4: width of the step-count field.

- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset, synchronous and active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  3  operation code.
- cmd_count  in  CNT_W  number of steps for SHL/SHR/ROL/ROR/ASR.
- p_in  in  WIDTH  parallel load data.
- s_in_l  in  LANE  serial bits entering the LSB end on SHL; sampled every step.
- s_in_r  in  LANE  serial bits entering the MSB end on SHR; sampled every step.
- out  out  WIDTH  register contents.
- s_out  out  LANE  bits that left the register on the most recent step.
- busy  out  1  a multi-step operation is in progress.
- done  out  1  one-cycle completion pulse.

## Operation
- Op codes:
  - 0 NOP
  - 1 SHL: out = {out[WIDTH-LANE-1:0], s_in_l}
  - 2 SHR: out = {s_in_r, out[WIDTH-1:LANE]}
  - 3 LOAD: out = p_in
  - 4 ROL
  - 5 ROR
  - 6 ASR: the top LANE bits take out[WIDTH-1]
  - 7 CLEAR: out = 0 and s_out = 0
- Handshake:
  - A command is accepted on a rising edge where cmd_valid and cmd_ready are both high.
  - cmd_ready = !busy && !rst.
  - cmd_valid while busy is ignored. It is not queued.
- FSM has two states, IDLE and RUN. A remaining-step counter has width CNT_W.
- On acceptance, NOP, LOAD and CLEAR take effect at the acceptance edge. The FSM stays in IDLE.
- On acceptance of a step op with cmd_count = N:
  - N = 0: no step; out and s_out are unchanged; the FSM stays in IDLE.
  - N = 1: one step at the acceptance edge; the FSM stays in IDLE.
  - N ≥ 2: step 1 occurs at the acceptance edge, and the FSM enters RUN with remaining = N-1. Each RUN edge performs one step and decrements remaining. When remaining reaches 1, the next edge performs the final step and the FSM returns to IDLE.
- s_out on each step:
  - SHL/ROL: out[WIDTH-1 -: LANE] (pre-step value).
  - SHR/ROR/ASR: out[LANE-1:0] (pre-step value).
  - Otherwise s_out holds.
- done goes high for exactly one cycle, registered, in the cycle after the edge that completes any accepted command, including NOP and N = 0.
- The op code is latched at acceptance. cmd_op and cmd_count are don't-care during RUN.
- The cmd_count width is not clamped. A rotate by WIDTH/LANE steps returns the original value.

## Timing
- Reset values: out = 0, s_out = 0, busy = 0, done = 0, FSM = IDLE, remaining = 0. cmd_ready is 0 while rst is high and 1 on the first cycle after release.
- Reset mid-RUN aborts the operation at that edge. There is no done pulse and the partial result is discarded.
- Latency for an N-step op: N edges from acceptance to the final value. busy is high for N-1 cycles. done is high in cycle N (cycle 0 is the acceptance cycle).
- Back-to-back: a new command can be accepted in the same cycle done is high.
- out, s_out, busy and done are all registered. cmd_ready is combinational from busy and rst only.

## Structure
- Package shift_reg_pkg holds:
  - the op-code localparams (OP_NOP … OP_CLEAR)
  - the state enum (S_IDLE, S_RUN)
- One combinational sub-module, shift_reg_step. It takes the current word, the op, s_in_l and s_in_r. It returns the next word and the s_out lanes. It is shared by the acceptance edge and the RUN edges.

## Test plan
- Reset: hold rst for 2 cycles with cmd_valid = 1 → out = 0x00, s_out = 0, busy = 0, done = 0, cmd_ready = 0 during reset and 1 after.
- LOAD 0xA5 → out = 0xA5 after the acceptance edge. done pulses once the next cycle. busy stays 0.
- SHL N = 3, s_in_l = 1, starting from 0xA5:
  - out steps 0x4B, 0x97, 0x2F; s_out steps 1, 0, 1.
  - busy is high for 2 cycles, then done.
  - cmd_valid asserted while busy is ignored.
- ROR N = 4 from 0x2F → 0xF2 with s_out = 1. ASR N = 2 from 0x80 → 0xE0 with s_out = 0. N = 0 → out unchanged and done the next cycle.
- LANE = 2 instance: SHL N = 1 from 0x81 with s_in_l = 2'b11 → out = 0x07, s_out = 2'b10.
- SHR N = 8 from 0xFF, with rst asserted on the 3rd RUN cycle → out = 0x00, no done pulse, cmd_ready = 1 the cycle after reset release.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared op codes, FSM state type and op classification for the shift register engine.
package shift_reg_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOP   = 3'd0;
  localparam logic [OP_W-1:0] OP_SHL   = 3'd1;
  localparam logic [OP_W-1:0] OP_SHR   = 3'd2;
  localparam logic [OP_W-1:0] OP_LOAD  = 3'd3;
  localparam logic [OP_W-1:0] OP_ROL   = 3'd4;
  localparam logic [OP_W-1:0] OP_ROR   = 3'd5;
  localparam logic [OP_W-1:0] OP_ASR   = 3'd6;
  localparam logic [OP_W-1:0] OP_CLEAR = 3'd7;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  // Ops that move lanes and honour the step count.
  function automatic logic is_step_op(input logic [OP_W-1:0] op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) ||
           (op == OP_ROR) || (op == OP_ASR);
  endfunction

endpackage

// File: rtl/shift_reg_step.sv
// One lane-wide step of the shift/rotate datapath; purely combinational.
module shift_reg_step
  import shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANE  = 1
) (
  input  logic [WIDTH-1:0] cur_word,
  input  logic [OP_W-1:0]  op,
  input  logic [LANE-1:0]  s_in_l,
  input  logic [LANE-1:0]  s_in_r,
  output logic [WIDTH-1:0] next_word_c,
  output logic [LANE-1:0]  lanes_c
);

  always_comb begin
    next_word_c = cur_word;
    lanes_c     = '0;
    case (op)
      OP_SHL: begin
        next_word_c = {cur_word[WIDTH-LANE-1:0], s_in_l};
        lanes_c     = cur_word[WIDTH-1 -: LANE];
      end
      OP_SHR: begin
        next_word_c = {s_in_r, cur_word[WIDTH-1:LANE]};
        lanes_c     = cur_word[LANE-1:0];
      end
      OP_ROL: begin
        next_word_c = {cur_word[WIDTH-LANE-1:0], cur_word[WIDTH-1 -: LANE]};
        lanes_c     = cur_word[WIDTH-1 -: LANE];
      end
      OP_ROR: begin
        next_word_c = {cur_word[LANE-1:0], cur_word[WIDTH-1:LANE]};
        lanes_c     = cur_word[LANE-1:0];
      end
      OP_ASR: begin
        next_word_c = {{LANE{cur_word[WIDTH-1]}}, cur_word[WIDTH-1:LANE]};
        lanes_c     = cur_word[LANE-1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/shift_reg_engine.sv
// Command-driven multi-step shift/rotate register with valid/ready issue and done pulse.
module shift_reg_engine
  import shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANE  = 1,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] p_in,
  input  logic [LANE-1:0]  s_in_l,
  input  logic [LANE-1:0]  s_in_r,
  output logic [WIDTH-1:0] out,
  output logic [LANE-1:0]  s_out,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0] out_d;
  logic [LANE-1:0]  s_out_d;
  logic             busy_d, done_d;

  logic             accept_c;
  logic [OP_W-1:0]  step_op_c;
  logic [WIDTH-1:0] step_word_c;
  logic [LANE-1:0]  step_lanes_c;

  // Ready only depends on busy and reset so upstream sees no loop through cmd_valid.
  assign cmd_ready = !busy && !rst;
  assign accept_c  = cmd_valid && cmd_ready;
  assign step_op_c = (state_q == S_RUN) ? op_q : OP_W'(cmd_op);

  shift_reg_step #(
    .WIDTH (WIDTH),
    .LANE  (LANE)
  ) u_step (
    .cur_word    (out),
    .op          (step_op_c),
    .s_in_l      (s_in_l),
    .s_in_r      (s_in_r),
    .next_word_c (step_word_c),
    .lanes_c     (step_lanes_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      op_q        <= OP_NOP;
      out         <= '0;
      s_out       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      op_q        <= op_d;
      out         <= out_d;
      s_out       <= s_out_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    op_d        = op_q;
    out_d       = out;
    s_out_d     = s_out;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          op_d = OP_W'(cmd_op);
          if (is_step_op(OP_W'(cmd_op))) begin
            if (cmd_count == '0) begin
              done_d = 1'b1;
            end else begin
              out_d   = step_word_c;
              s_out_d = step_lanes_c;
              if (cmd_count == CNT_W'(1)) begin
                done_d = 1'b1;
              end else begin
                state_d     = S_RUN;
                remaining_d = cmd_count - CNT_W'(1);
                busy_d      = 1'b1;
              end
            end
          end else begin
            done_d = 1'b1;
            if (OP_W'(cmd_op) == OP_LOAD) begin
              out_d = p_in;
            end else if (OP_W'(cmd_op) == OP_CLEAR) begin
              out_d   = '0;
              s_out_d = '0;
            end
          end
        end
      end

      S_RUN: begin
        out_d   = step_word_c;
        s_out_d = step_lanes_c;
        if (remaining_q == CNT_W'(1)) begin
          state_d     = S_IDLE;
          remaining_d = '0;
          done_d      = 1'b1;
        end else begin
          remaining_d = remaining_q - CNT_W'(1);
          busy_d      = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule
